display_scan_scheduler: RTL and testbench



---
 rtl/display_scan_scheduler.sv | 66 ++++++
 tb/tb_display_scan_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: seven-segment digit scanner with per-slot blanking and frame-synchronous shadow text load
module display_scan_scheduler #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 5000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load_req,
  output logic                    load_ack,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              seg
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [8*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0]   shadow_en, shadow_en_nxt, anode_nxt;
  logic [7:0]              seg_nxt;
  logic                    wrap, boundary, capture, show;

  // Next slot position, boundary capture, and the outputs for the upcoming cycle
  always_comb begin
    wrap          = cnt == CNT_MAX;
    boundary      = wrap && idx == IDX_MAX;
    capture       = boundary && load_req;
    cnt_nxt       = wrap ? '0 : cnt + CW'(1);
    idx_nxt       = !wrap ? idx : boundary ? '0 : idx + IW'(1);
    shadow_nxt    = capture ? digits_in : shadow;
    shadow_en_nxt = capture ? digit_en : shadow_en;
    show          = cnt_nxt >= BLANK_END && shadow_en_nxt[idx_nxt];
    anode_nxt     = show ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
    seg_nxt       = show ? ~shadow_nxt[{idx_nxt, 3'b000} +: 8] : 8'hFF;
  end

  // State and registered outputs; reset blanks the bus at once and clears the text
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_en  <= '0;
      anode      <= '1;
      seg        <= 8'hFF;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      shadow_en  <= shadow_en_nxt;
      anode      <= anode_nxt;
      seg        <= seg_nxt;
      load_ack   <= capture;
      frame_done <= boundary;
    end
  end
endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb_display_scan_scheduler: table vectors, hand sequences and a random run against a slot-arithmetic model
module tb_display_scan_scheduler;
  localparam int ND = 4, SD = 10, BC = 2, FL = ND * SD;

  logic        clk = 1'b0, reset_n = 1'b0, load_req = 1'b0;
  logic [31:0] digits_in = '0;
  logic [3:0]  digit_en = '0;
  logic        load_ack, frame_done;
  logic [3:0]  anode;
  logic [7:0]  seg;

  display_scan_scheduler #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .digit_en(digit_en),
    .load_req(load_req), .load_ack(load_ack), .frame_done(frame_done),
    .anode(anode), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int t = 0;
  logic [31:0] sh = '0;
  logic [3:0]  se = '0;
  logic        m_ack = 1'b0, m_fd = 1'b0;

  typedef struct {
    logic [31:0] digits;
    logic [3:0]  en;
    logic [15:0] an;
    logic [31:0] sg;
  } vec_t;
  vec_t tab[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  // One clock edge: apply the capture rule to the model, then compare all outputs
  task automatic tick();
    int k, d;
    logic [3:0] ea;
    logic [7:0] es;
    logic       bnd;
    @(posedge clk);
    bnd = (t % FL) == FL - 1;
    m_ack = bnd && load_req;
    m_fd = bnd;
    if (m_ack) begin
      sh = digits_in;
      se = digit_en;
    end
    t++;
    #1;
    k = t % SD;
    d = (t / SD) % ND;
    ea = 4'hF;
    es = 8'hFF;
    if (k >= BC && se[d]) begin
      ea[d] = 1'b0;
      es = ~sh[d*8 +: 8];
    end
    check("anode", 32'(anode), 32'(ea));
    check("seg", 32'(seg), 32'(es));
    check("load_ack", 32'(load_ack), 32'(m_ack));
    check("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic to_boundary();
    while (t % FL != FL - 1) tick();
  endtask

  task automatic release_reset();
    #3;
    reset_n = 1'b1;
    t = 0;
    sh = '0;
    se = '0;
  endtask

  initial begin
    int acks;
    tab[0] = '{32'h3F065B4F, 4'hF,    16'h7BDE, 32'hC0F9A4B0};
    tab[1] = '{32'h3F065B4F, 4'b0101, 16'hFBFE, 32'hFFF9FFB0};
    tab[2] = '{32'h80FF0001, 4'b1010, 16'h7FDF, 32'h7FFFFFFF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_ack", 32'(load_ack), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    release_reset();

    repeat (2 * FL + 5) tick();

    for (int i = 0; i < 3; i++) begin
      to_boundary();
      digits_in = tab[i].digits;
      digit_en = tab[i].en;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      digits_in = 32'h12345678;
      digit_en = 4'hF;
      check("tab_ack", 32'(load_ack), 32'h1);
      for (int j = 1; j < FL; j++) begin
        tick();
        if (t % SD == 5) begin
          check("tab_anode", 32'(anode), 32'(tab[i].an[((t / SD) % ND)*4 +: 4]));
          check("tab_seg", 32'(seg), 32'(tab[i].sg[((t / SD) % ND)*8 +: 8]));
        end
      end
    end

    while (t % FL != 5) tick();
    load_req = 1'b1;
    acks = 0;
    for (int j = 0; j < FL + 10; j++) begin
      if (j == 3 || j == 12 || j == 30) digits_in = $urandom;
      digit_en = 4'hF;
      tick();
      if (load_ack) acks++;
      if (m_ack) load_req = 1'b0;
    end
    check("single_ack", 32'(acks), 32'd1);

    to_boundary();
    tick();
    digits_in = 32'hA5A5A5A5;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    repeat (FL) tick();

    to_boundary();
    digits_in = tab[0].digits;
    digit_en = 4'hF;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    while (t % FL != 25) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_anode", 32'(anode), 32'hF);
    check("async_seg", 32'(seg), 32'hFF);
    @(posedge clk);
    #1;
    check("hold_anode", 32'(anode), 32'hF);
    check("hold_fd", 32'(frame_done), 32'h0);
    release_reset();
    repeat (FL + 15) tick();

    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(3) == 0) digits_in = $urandom;
      if ($urandom_range(3) == 0) digit_en = 4'($urandom);
      if ($urandom_range(4) == 0) load_req = ~load_req;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
